// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock; WIDTH-cycle latency.
// No backpressure: start is only accepted while idle, and requests made while busy are dropped.

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd, dvs, quo;
  logic [WIDTH:0]   prem, shifted, dvs_ext, diff, prem_nxt;
  logic [WIDTH+1:0] carry;
  logic [CW-1:0]    cnt;
  logic             accept, last, qbit;
  logic             unused_prem_msb;

  assign shifted = {prem[WIDTH-1:0], dvd[WIDTH-1]};
  assign dvs_ext = {1'b0, dvs};
  assign carry[0] = 1'b1;

  // Two's-complement subtract: shifted + ~divisor + 1; carry-out high means no borrow.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_adder u_fa (
      .in1  (shifted[i]),
      .in2  (~dvs_ext[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign qbit     = carry[WIDTH+1];
  assign prem_nxt = qbit ? diff : shifted;

  // After every restoring step the partial remainder is below the divisor, so its MSB stays 0.
  assign unused_prem_msb = prem[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start && divisor != '0) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      prem        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd  <= dividend;
        dvs  <= divisor;
        quo  <= '0;
        prem <= '0;
        cnt  <= CW'(WIDTH);
        busy <= 1'b1;
      end else if (state == IDLE && start) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
      if (state == CALC) begin
        prem <= prem_nxt;
        dvd  <= {dvd[WIDTH-2:0], 1'b0};
        quo  <= {quo[WIDTH-2:0], qbit};
        cnt  <= cnt - CW'(1);
        if (last) begin
          quotient    <= {quo[WIDTH-2:0], qbit};
          remainder   <= prem_nxt[WIDTH-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: transaction-level reference model compared every cycle, plus literal cases.

module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  // Reference model: request-level view with plain / and %.
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_q, m_r, m_a, m_b;
  int           m_left;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= m_a / m_b;
          m_r    <= m_a % m_b;
          m_dz   <= 1'b0;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        if (divisor == 0) begin
          m_q    <= '1;
          m_r    <= dividend;
          m_dz   <= 1'b1;
          m_done <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_left <= W;
          m_a    <= dividend;
          m_b    <= divisor;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", div_by_zero, m_dz);
    if (done && !div_by_zero) begin
      check("identity", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
      check("rem_bound", 32'(remainder < m_b), 32'd1);
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  // lat = number of clock edges after the start edge at which done appeared.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done for %0d/%0d", a, b);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int ndone;
    logic [W-1:0] seen_q, seen_r;

    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(100, 7, lat);
    check("lat_100_7", lat, W);
    check("q_100_7", quotient, 14);
    check("r_100_7", remainder, 2);
    check("dz_100_7", div_by_zero, 0);
    check("busy_in_done", busy, 0);
    @(negedge clk);

    run_div(255, 1, lat);
    check("q_255_1", quotient, 255);
    check("r_255_1", remainder, 0);
    @(negedge clk);
    run_div(5, 9, lat);
    check("q_5_9", quotient, 0);
    check("r_5_9", remainder, 5);
    @(negedge clk);
    run_div(255, 255, lat);
    check("q_255_255", quotient, 1);
    check("r_255_255", remainder, 0);
    @(negedge clk);

    run_div(77, 0, lat);
    check("lat_div0", lat, 0);
    check("q_div0", quotient, 255);
    check("r_div0", remainder, 77);
    check("dz_div0", div_by_zero, 1);
    check("busy_div0", busy, 0);
    @(negedge clk);
    check("done_single_div0", done, 0);

    // Second request while busy must be dropped.
    dividend = 200;
    divisor  = 3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 10;
    divisor  = 2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 0;
    divisor  = 0;
    ndone    = 0;
    seen_q   = '0;
    seen_r   = '0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        seen_q = quotient;
        seen_r = remainder;
      end
    end
    check("ignored_ndone", ndone, 1);
    check("ignored_q", seen_q, 66);
    check("ignored_r", seen_r, 2);

    // Reset mid-operation aborts with no done.
    dividend = 200;
    divisor  = 3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_by_zero, 0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_div(100, 7, lat);
    check("b2b_q1", quotient, 14);
    check("b2b_r1", remainder, 2);
    run_div(9, 4, lat);
    check("b2b_lat2", lat, W);
    check("b2b_q2", quotient, 2);
    check("b2b_r2", remainder, 1);
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      case ($urandom_range(0, 9))
        0:       divisor = '0;
        1:       divisor = W'(1);
        2:       divisor = '1;
        default: divisor = W'($urandom_range(1, (1 << W) - 1));
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
